// File: rtl/sdi_packet_framer.sv
// Transmit-side SDI packet framer: header / BRAM payload / trailer / idle gap.
// Optional macro SDI_FRAMER_CHECKSUM_EN makes the trailer the XOR of the payload words.
module sdi_packet_framer #(
  parameter logic [31:0] IDLE_WORD   = 32'h000000BC,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter logic [11:0] MAX_PAYLOAD = 12'd4093
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [11:0] i_dest_addr,
  input  logic [11:0] i_payload_len,
  input  logic [15:0] i_base_addr,
  output logic        o_rd_en,
  output logic [15:0] o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_tx_data,
  output logic        o_tx_char_is_k,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_TRAILER = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam logic [7:0] K28_2    = 8'h5C;
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_tx_data;
  logic        r_tx_k;
  logic        r_pay_sel;
  logic        r_rd_en;
  logic [15:0] r_rd_addr;
  logic [11:0] r_rd_left;
  logic [11:0] r_pay_left;
  logic [7:0]  r_gap_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [31:0] w_trailer;
  logic        w_len_ok;

  assign w_len_ok = (i_payload_len != 12'd0) && (i_payload_len <= MAX_PAYLOAD);

`ifdef SDI_FRAMER_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_csum <= 32'h0;
    end else if (r_state == S_HEADER) begin
      r_csum <= 32'h0;
    end else if (r_state == S_PAYLOAD) begin
      r_csum <= r_csum ^ i_rd_data;
    end
  end

  // The last payload word is still on i_rd_data when the trailer is loaded.
  assign w_trailer = r_csum ^ i_rd_data;
`else
  assign w_trailer = 32'h0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tx_data  <= IDLE_WORD;
      r_tx_k     <= 1'b1;
      r_pay_sel  <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= 16'h0;
      r_rd_left  <= 12'h0;
      r_pay_left <= 12'h0;
      r_gap_cnt  <= 8'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // Read issue runs one cycle ahead of the payload output, N reads per packet.
      if (r_rd_en) begin
        if (r_rd_left != 12'd0) begin
          r_rd_addr <= r_rd_addr + 16'd1;
          r_rd_left <= r_rd_left - 12'd1;
        end else begin
          r_rd_en <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_state    <= S_HEADER;
              r_tx_data  <= {i_payload_len + 12'd2, i_dest_addr, K28_2};
              r_tx_k     <= 1'b1;
              r_busy     <= 1'b1;
              r_rd_en    <= 1'b1;
              r_rd_addr  <= i_base_addr;
              r_rd_left  <= i_payload_len - 12'd1;
              r_pay_left <= i_payload_len;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          r_state   <= S_PAYLOAD;
          r_pay_sel <= 1'b1;
          r_tx_k    <= 1'b0;
        end
        S_PAYLOAD: begin
          r_pay_left <= r_pay_left - 12'd1;
          if (r_pay_left == 12'd1) begin
            r_state   <= S_TRAILER;
            r_pay_sel <= 1'b0;
            r_tx_data <= w_trailer;
          end
        end
        S_TRAILER: begin
          r_state   <= S_GAP;
          r_tx_data <= IDLE_WORD;
          r_tx_k    <= 1'b1;
          r_gap_cnt <= GAP_LAST;
          r_done    <= (GAP_LAST == 8'd0);
        end
        S_GAP: begin
          if (r_gap_cnt == 8'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
            r_done    <= (r_gap_cnt == 8'd1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload words come straight from the BRAM output register under a registered select.
  assign o_tx_data      = r_pay_sel ? i_rd_data : r_tx_data;
  assign o_tx_char_is_k = r_tx_k;
  assign o_rd_en        = r_rd_en;
  assign o_rd_addr      = r_rd_addr;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_state        = r_state;

endmodule
